// File: rtl/spi_pkg.sv
// Shared constants and types for the write-only SPI control-register peripheral.
package spi_pkg;

    // One frame: R/W flag, 7-bit address, 8-bit data.
    localparam int FRAME_BITS = 16;

    // Register map seen by the PWM block.
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_peripheral_input_sync.sv
// Multi-flop synchronizer for one raw pin, followed by a history flop so the
// parent can detect edges by comparing the synchronized value with its past.
module input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic dout_prev
);

    // chain[SYNC_STAGES-1] is the synchronized level, chain[SYNC_STAGES] its history.
    logic [SYNC_STAGES:0] chain;

    // Shift the raw pin through the synchronizer and history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {(SYNC_STAGES + 1){RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-1:0], din};
        end
    end

    assign dout      = chain[SYNC_STAGES-1];
    assign dout_prev = chain[SYNC_STAGES];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only peripheral. Oversamples nCS/SCLK/COPI on clk, assembles
// 16-bit frames and writes the five PWM control registers.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nCS,
    input  logic       SCLK,
    input  logic       COPI,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_valid
);

    logic ncs_s, ncs_h;
    logic sclk_s, sclk_h;
    logic copi_s;

    input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(nCS), .dout(ncs_s), .dout_prev(ncs_h)
    );

    input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK), .dout(sclk_s), .dout_prev(sclk_h)
    );

    // COPI only needs its level; it shares the same depth as SCLK so the bit
    // stable around the raw SCLK rise is what gets captured.
    input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(COPI), .dout(copi_s), .dout_prev()
    );

    logic ncs_fall, ncs_rise, sclk_rise;
    assign ncs_fall  = ~ncs_s & ncs_h;
    assign ncs_rise  = ncs_s & ~ncs_h;
    assign sclk_rise = sclk_s & ~sclk_h;

    spi_state_t                state;
    logic [FRAME_BITS-1:0]     shreg;
    logic [4:0]                bit_cnt;

    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    assign frame_addr = shreg[14:8];
    assign frame_data = shreg[7:0];

    // Frame FSM: capture bits while selected, then commit a complete write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            txn_valid       <= 1'b0;
        end else begin
            txn_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state   <= SHIFT;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // Deselect wins over a coincident clock edge.
                    if (ncs_rise) begin
                        state <= (bit_cnt == 5'(FRAME_BITS)) ? COMMIT : IDLE;
                    end else if (sclk_rise && (bit_cnt < 5'(FRAME_BITS))) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], copi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (shreg[15] && (frame_addr <= 7'(MAX_ADDR))) begin
                        txn_valid <= 1'b1;
                        case (frame_addr)
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                            ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized scoreboard bench for spi_peripheral: frames are driven bit-serially,
// a register-image model predicts each commit, and a monitor checks every pulse.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nCS = 1'b1;
    logic       SCLK = 1'b0;
    logic       COPI = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       txn_valid;

    spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .txn_valid(txn_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int n_expected = 0;

    // Reference register image, indexed by address.
    logic [7:0]  mdl [5];
    logic [39:0] q_regs [$];
    int          q_cyc  [$];

    function automatic logic [39:0] model_regs();
        return {mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every txn_valid pulse must match the oldest predicted commit.
    always @(negedge clk) begin
        if (rst_n && txn_valid) begin
            n_pulse++;
            if (q_regs.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_txn: got pulse at cycle %0d, expected none", cyc);
            end else begin
                check("commit_regs", dut_regs(), q_regs.pop_front());
                check("commit_latency", 40'(cyc), 40'(q_cyc.pop_front()));
            end
        end
    end

    task automatic shift_bit(input logic b, input int half);
        COPI = b;
        repeat (half) @(negedge clk);
        SCLK = 1'b1;
        repeat (half) @(negedge clk);
        SCLK = 1'b0;
    endtask

    // Drive nbits bits MSB-first taken from bits[nbits-1:0]; hi_cycles is the nCS-high gap after.
    task automatic send_frame(input logic [31:0] bits, input int nbits, input int half, input int hi_cycles);
        logic [15:0] w;
        @(negedge clk);
        nCS = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) shift_bit(bits[nbits-1-i], half);
        repeat (half) @(negedge clk);
        nCS = 1'b1;
        if (nbits >= 16) begin
            w = 16'(bits >> (nbits - 16));
            if (w[15] && (int'(w[14:8]) <= 4)) begin
                mdl[int'(w[14:8])] = w[7:0];
                q_regs.push_back(model_regs());
                // nCS sampled high at cycle+1, COMMIT at +3, visible after +4.
                q_cyc.push_back(cyc + 4);
                n_expected++;
            end
        end
        repeat (hi_cycles - 1) @(negedge clk);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] word;
        logic [31:0] bits;
        int          nb, r;

        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;

        repeat (4) @(negedge clk);
        check("reset_regs", dut_regs(), 40'h0);
        check("reset_txn", 40'(txn_valid), 40'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic writes.
        send_frame(32'h8001, 16, 4, 6);
        send_frame(32'h847F, 16, 4, 6);
        settle();
        check("basic_writes", dut_regs(), 40'h7F_00_00_00_01);

        // Read frame and out-of-range writes leave registers alone.
        send_frame(32'h02AA, 16, 4, 6);
        send_frame(32'h85FF, 16, 4, 6);
        send_frame(32'hFF11, 16, 4, 6);
        settle();
        check("read_and_bad_addr", dut_regs(), 40'h7F_00_00_00_01);

        // SCLK toggling while deselected is ignored.
        for (int i = 0; i < 5; i++) shift_bit(1'b1, 4);
        settle();

        // Short frame discarded; long frame keeps its first 16 bits.
        send_frame(32'h0000_0835, 12, 4, 6);
        send_frame(32'h0008_35A9, 20, 4, 6);
        settle();
        check("short_long", dut_regs(), 40'h7F_5A_00_00_01);

        // Reset in the middle of a write to address 0x01.
        @(negedge clk);
        nCS = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) shift_bit(1'(8'h81 >> (7 - i)), 4);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("midframe_reset_regs", dut_regs(), 40'h0);
        check("midframe_reset_txn", 40'(txn_valid), 40'h0);
        nCS = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(32'h81C3, 16, 4, 6);
        settle();
        check("after_reset_write", dut_regs(), 40'h00_00_00_C3_00);

        // Back-to-back writes with the minimum deselect gap.
        send_frame(32'h8233, 16, 4, 3);
        send_frame(32'h83CC, 16, 4, 3);
        settle();
        check("back_to_back", dut_regs(), 40'h00_CC_33_C3_00);

        // Randomized frames.
        for (int t = 0; t < 30; t++) begin
            word[15]   = ($urandom_range(0, 3) != 0);
            word[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            word[7:0]  = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      nb = $urandom_range(1, 15);
            else if (r == 1) nb = $urandom_range(17, 24);
            else             nb = 16;
            if (nb < 16) bits = 32'(word >> (16 - nb));
            else         bits = (32'(word) << (nb - 16)) | (32'($urandom) & ((32'd1 << (nb - 16)) - 32'd1));
            send_frame(bits, nb, $urandom_range(3, 6), $urandom_range(3, 8));
        end
        settle();

        check("final_regs", dut_regs(), model_regs());
        check("pending_commits", 40'(q_regs.size()), 40'h0);
        check("pulse_count", 40'(n_pulse), 40'(n_expected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Write-only SPI mode-0 peripheral sitting directly upstream of the PWM generator inside `tt_um_uwasic_onboarding_edson`. Samples raw `nCS`/`SCLK`/`COPI` pins (from `ui_in[2:0]`) in the system clock domain, decodes 16-bit frames and updates five 8-bit control registers consumed by the PWM block. No SPI clock domain exists; all logic runs on `clk`.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each input synchronizer (≥2).
- `MAX_ADDR`, 4: highest writable register address; writes above it are dropped.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `nCS` in 1: raw chip select, active-low, asynchronous to `clk`.
- `SCLK` in 1: raw SPI clock, idle low, asynchronous to `clk`.
- `COPI` in 1: raw serial data, MSB first, asynchronous to `clk`.
- `en_reg_out_7_0` out 8: address 0x00, output enables bits 7:0.
- `en_reg_out_15_8` out 8: address 0x01, output enables bits 15:8.
- `en_reg_pwm_7_0` out 8: address 0x02, PWM mode select bits 7:0.
- `en_reg_pwm_15_8` out 8: address 0x03, PWM mode select bits 15:8.
- `pwm_duty_cycle` out 8: address 0x04, duty cycle (0x00 = 0 %, 0xFF = 100 %).
- `txn_valid` out 1: one-cycle pulse when a complete, accepted write commits.

## Operation
- Frame: 16 bits, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Each input passes through `SYNC_STAGES` flops plus one history flop; edges detected on the synchronized value vs. history.
- Synchronizer reset values: `nCS`=1, `SCLK`=0, `COPI`=0.
- FSM states IDLE, SHIFT, COMMIT:
  - IDLE: synchronized `nCS` falling edge -> SHIFT; clear 16-bit shift register and 5-bit bit counter.
  - SHIFT: on each synchronized `SCLK` rising edge, shift synchronized `COPI` into LSB, counter +1. Counter saturates at 16; further edges neither shift nor count.
  - SHIFT: synchronized `nCS` rising edge -> COMMIT if counter == 16, else IDLE (frame discarded, no register change).
  - COMMIT (one cycle): if bit15 == 1 and address ≤ `MAX_ADDR`, write data to addressed register and pulse `txn_valid`; otherwise no write, no pulse. Always -> IDLE.
- Read frames (bit15 = 0) are accepted and ignored; no data returned (no CIPO).
- `SCLK` edges seen while `nCS` is high are ignored.
- Asynchronous reset at any time, including mid-frame: all five registers 0x00, `txn_valid` 0, FSM IDLE, counter/shift register 0. A frame already in progress when reset releases is seen as starting at its next falling `nCS`. Frames caught mid-flight with <16 captured edges are discarded.

## Timing
- Reset value of every output: 0.
- Input constraint: `SCLK` high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods. `nCS` setup before first `SCLK` rise and hold after last `SCLK` fall each ≥ same.
- `COPI` is sampled when the synchronized `SCLK` rise is detected; both go through identical synchronizer depth, so data stable around the raw rise is captured.
- Commit latency (SYNC_STAGES=2): FSM enters COMMIT on the 2nd `clk` rising edge after raw `nCS` is first sampled high. Register and `txn_valid` update on the 3rd.
- `txn_valid` high exactly one cycle, coincident with the first cycle the new register value is visible.
- Back-to-back frames: a new `nCS` fall may be detected the cycle after COMMIT; no frame is lost if `nCS` stays high ≥ `SYNC_STAGES`+1 cycles.

## Structure
- Package `spi_pkg`: `FRAME_BITS`=16, register address constants `ADDR_EN_OUT_LO`..`ADDR_DUTY` (0x00–0x04), FSM state enum `spi_state_t`.
- Sub-module `input_sync`: parameterised `SYNC_STAGES` synchronizer with reset value parameter, instantiated three times.
- Register file stays inside `spi_peripheral`.

## Test plan
- Write 0x80 0x01 (addr 0x00) then 0x84 0x7F -> `en_reg_out_7_0`=0x01, `pwm_duty_cycle`=0x7F, each with one `txn_valid` pulse; other registers remain 0x00.
- Read frame 0x02 0xAA -> no register change, no `txn_valid`.
- Write to address 0x05 data 0xFF, and 0x7F data 0x11 -> all registers unchanged, no `txn_valid`.
- Short frame: 12 `SCLK` edges, then `nCS` rise -> discarded. Long frame: 20 edges carrying 0x83 0x5A then 4 extra bits -> `en_reg_pwm_15_8`=0x5A.
- Assert `rst_n` low after 8 bits of a write to 0x01 -> all outputs 0. Next full frame 0x81 0xC3 -> `en_reg_out_15_8`=0xC3.
- Back-to-back writes to 0x02 and 0x03 with minimum `nCS` high gap, `SCLK` at `clk`/8 -> both registers updated, two `txn_valid` pulses, latency 3 cycles after `nCS` rise.
